mul_pipe: RTL and testbench
===========================

MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32, 64.
REQ-002 SHALL have parameter LAT, default 2, issue-to-result latency in cycles; legal values 2..4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port InValid  input  1  operand request valid.
REQ-006 SHALL have port InReady  output  1  block can accept a request this cycle.
REQ-007 SHALL have port Funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
REQ-008 SHALL have port WordOp  input  1  32-bit MULW op; ignored when XLEN=32.
REQ-009 SHALL have port SrcA  input  XLEN  multiplicand; signed for MULH and MULHSU.
REQ-010 SHALL have port SrcB  input  XLEN  multiplier; signed for MULH only.
REQ-011 SHALL have port Flush  input  1  discard all in-flight operations.
REQ-012 SHALL have port OutValid  output  1  Result holds a completed operation.
REQ-013 SHALL have port OutReady  input  1  consumer accepts Result.
REQ-014 SHALL have port Result  output  XLEN  selected product word.
REQ-015 SHALL have port Busy  output  1  at least one pipeline stage holds a valid op.

Function
REQ-016 SHALL implement LAT pipeline stages, each with one valid bit and its own op/operand or partial-sum state.
REQ-017 SHALL define advance = ~OutValid | OutReady; when advance=1, all stages shift forward one position; otherwise all stages hold.
REQ-018 SHALL drive InReady = advance; a request is accepted when InValid & InReady.
REQ-019 SHALL, absent backpressure, assert OutValid exactly LAT cycles after the acceptance edge.
REQ-020 SHALL sustain one accepted op per cycle with no bubbles while OutReady=1.
REQ-021 SHALL deliver results in acceptance order, without loss or duplication under any OutReady pattern.
REQ-022 SHALL hold Result and OutValid stable while OutValid=1 and OutReady=0.
REQ-023 SHALL produce Result = low XLEN bits of the 2*XLEN product for MUL.
REQ-024 SHALL produce Result = high XLEN bits of signed×signed product for MULH, signed×unsigned for MULHSU, and unsigned×unsigned for MULHU.
REQ-025 SHALL treat Funct3[2]=1 as Funct3[1:0] with bit 2 ignored.
REQ-026 SHALL, when XLEN=64 and WordOp=1, multiply SrcA[31:0]×SrcB[31:0] and return the sign-extended low 32 bits of the product, regardless of Funct3.
REQ-027 SHALL, on Flush=1, clear every stage valid bit at that edge, discard any request accepted in the same cycle, and deassert OutValid on the following cycle.
REQ-028 SHALL accept requests normally in the cycle after Flush deasserts.
REQ-029 SHALL drive Busy = OR of all stage valid bits, including the output stage.
REQ-030 SHALL give data registers no functional effect when their stage valid bit is 0.

Reset
REQ-031 SHALL, while reset=0, asynchronously clear all valid bits, with OutValid=0, Busy=0, Result=0 and InReady=1 as soon as reset deasserts.
REQ-032 SHALL drop any operation in flight when reset asserts mid-operation, with no stale result delivered after release.
REQ-033 SHALL accept a request on the first rising edge after reset deasserts.

Verification
REQ-034 SHALL pass this test with XLEN=32, LAT=2 and OutReady=1.
- Stimulus: MUL, MULH, MULHSU, MULHU issued back-to-back, all with A=B=0xFFFFFFFF.
- Response: results 0x00000001, 0x00000000, 0xFFFFFFFF, 0xFFFFFFFE on consecutive cycles starting 2 cycles after the first issue.
REQ-035 SHALL pass this test with XLEN=32.
- Stimulus: MULH A=B=0x80000000.
- Response: 0x40000000.
- Stimulus: MULHSU A=0x80000000, B=0x00000002.
- Response: 0xFFFFFFFF.
REQ-036 SHALL pass this test with LAT=3.
- Stimulus: issue MUL ops 3×5, 7×11, 13×17 back-to-back while OutReady=0 for 4 cycles, then OutReady=1.
- Response: InReady falls when the output stage fills; no request is lost; results 15, 77, 221 appear in order.
- Response: Result holds 15 throughout the stall.
REQ-037 SHALL pass this test with LAT=3.
- Stimulus: issue 2 ops, then pulse Flush one cycle after the second issue, with a new request InValid=1 in the flush cycle.
- Response: OutValid stays 0; Busy=0 on the cycle after the flush; the flush-cycle request is discarded.
- Response: the next request issued after Flush deasserts completes 3 cycles later with the correct value.
REQ-038 SHALL pass this test with XLEN=64.
- Stimulus: WordOp=1, A=0x000000007FFFFFFF, B=0x0000000000000002.
- Response: 0xFFFFFFFFFFFFFFFE.
- Stimulus: WordOp=0 MULHU, A=B=0xFFFFFFFFFFFFFFFF.
- Response: 0xFFFFFFFFFFFFFFFE.
REQ-039 SHALL pass this test.
- Stimulus: assert reset for one cycle while 2 ops are in flight.
- Response: OutValid=0 and Busy=0 immediately; no result from those ops ever appears.
- Response: a new op issued on the first edge after release completes after LAT cycles.

Source files
------------

// File: rtl/mul_pipe.sv
// mul_pipe: pipelined RISC-V M-extension multiplier (MUL/MULH/MULHSU/MULHU, MULW) with backpressure and flush
module mul_pipe #(
  parameter int XLEN = 32,
  parameter int LAT  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [2:0]      Funct3,
  input  logic            WordOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            Flush,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] Result,
  output logic            Busy
);
  logic [LAT-1:0]          v;
  logic [XLEN-1:0]         a0, b0;
  logic [1:0]              f0;
  logic                    w0;
  logic [XLEN-1:0]         rs [1:LAT-1];
  logic                    adv;
  logic signed [XLEN:0]    ea, eb;
  logic signed [2*XLEN-1:0] p;
  logic [XLEN-1:0]         sel;
  logic                    unused;
  assign unused   = Funct3[2];
  assign OutValid = v[LAT-1];
  assign Result   = rs[LAT-1];
  assign Busy     = |v;
  assign adv      = ~OutValid | OutReady;
  assign InReady  = adv;
  // multiply the stage-0 operands with per-op sign extension and pick the product word
  always_comb begin
    ea  = {a0[XLEN-1] & (f0 == 2'b01 || f0 == 2'b10), a0};
    eb  = {b0[XLEN-1] & (f0 == 2'b01), b0};
    p   = ea * eb;
    sel = (XLEN == 64 && w0) ? XLEN'($signed(p[31:0])) :
          (f0 == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  end
  // shift valid bits and stage data forward together whenever the output can advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v  <= '0;
      a0 <= '0;
      b0 <= '0;
      f0 <= '0;
      w0 <= 1'b0;
      for (int i = 1; i < LAT; i++) rs[i] <= '0;
    end else begin
      if (Flush) v <= '0;
      else if (adv) v <= {v[LAT-2:0], InValid};
      if (adv) begin
        a0    <= SrcA;
        b0    <= SrcB;
        f0    <= Funct3[1:0];
        w0    <= WordOp;
        rs[1] <= sel;
        for (int i = 2; i < LAT; i++) rs[i] <= rs[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed checks of mul_pipe in three configurations (32/LAT2, 32/LAT3, 64/LAT2)
module tb_mul_pipe;
  logic clk = 0, reset = 0, in_valid = 0, word_op = 0, flush = 0, out_ready = 1;
  logic [2:0]  funct3 = 0;
  logic [63:0] src_a = 0, src_b = 0;
  logic        rdy2, ov2, busy2, rdy3, ov3, busy3, rdy6, ov6, busy6;
  logic [31:0] res2, res3;
  logic [63:0] res6;
  int passed = 0, total = 0;

  typedef struct {
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b;
    logic [31:0] e32;
    logic [63:0] e64;
  } vec_t;
  localparam int N = 13;
  vec_t tv [N];

  always #5 clk = ~clk;

  mul_pipe #(.XLEN(32), .LAT(2)) u2 (.clk(clk), .reset(reset), .InValid(in_valid), .InReady(rdy2),
    .Funct3(funct3), .WordOp(word_op), .SrcA(src_a[31:0]), .SrcB(src_b[31:0]), .Flush(flush),
    .OutValid(ov2), .OutReady(out_ready), .Result(res2), .Busy(busy2));
  mul_pipe #(.XLEN(32), .LAT(3)) u3 (.clk(clk), .reset(reset), .InValid(in_valid), .InReady(rdy3),
    .Funct3(funct3), .WordOp(word_op), .SrcA(src_a[31:0]), .SrcB(src_b[31:0]), .Flush(flush),
    .OutValid(ov3), .OutReady(out_ready), .Result(res3), .Busy(busy3));
  mul_pipe #(.XLEN(64), .LAT(2)) u6 (.clk(clk), .reset(reset), .InValid(in_valid), .InReady(rdy6),
    .Funct3(funct3), .WordOp(word_op), .SrcA(src_a), .SrcB(src_b), .Flush(flush),
    .OutValid(ov6), .OutReady(out_ready), .Result(res6), .Busy(busy6));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] f, input logic w, input logic [63:0] a, input logic [63:0] b);
    in_valid = 1;
    funct3   = f;
    word_op  = w;
    src_a    = a;
    src_b    = b;
  endtask

  task automatic do_reset;
    reset = 0;
    in_valid = 0;
    repeat (2) step;
    reset = 1;
  endtask

  initial begin
    tv[0]  = '{3'd0, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 32'h00000001, 64'h1};
    tv[1]  = '{3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 32'h00000000, 64'h0};
    tv[2]  = '{3'd2, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    tv[3]  = '{3'd3, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
    tv[4]  = '{3'd1, 1'b0, 64'h00000000_80000000, 64'h00000000_80000000, 32'h40000000, 64'h0};
    tv[5]  = '{3'd2, 1'b0, 64'h00000000_80000000, 64'h2, 32'hFFFFFFFF, 64'h0};
    tv[6]  = '{3'd0, 1'b1, 64'h00000000_7FFFFFFF, 64'h2, 32'hFFFFFFFE, 64'hFFFFFFFF_FFFFFFFE};
    tv[7]  = '{3'd3, 1'b1, 64'hFFFFFFFF_00000003, 64'h12345678_00000005, 32'h0, 64'hF};
    tv[8]  = '{3'd5, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h2, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    tv[9]  = '{3'd0, 1'b0, 64'h00000001_00000000, 64'h3, 32'h0, 64'h00000003_00000000};
    tv[10] = '{3'd1, 1'b0, 64'hFFFFFFFF_FFFFFFFD, 64'h5, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    tv[11] = '{3'd2, 1'b0, 64'h2, 64'hFFFFFFFF_FFFFFFFF, 32'h1, 64'h1};
    tv[12] = '{3'd4, 1'b0, 64'h3, 64'h5, 32'd15, 64'd15};

    step;
    #1;
    chk("rst ov2", ov2, 0);
    chk("rst busy2", busy2, 0);
    chk("rst res2", res2, 0);
    chk("rst rdy2", rdy2, 1);
    chk("rst ov3", ov3, 0);
    chk("rst busy3", busy3, 0);
    chk("rst res6", res6, 0);
    chk("rst busy6", busy6, 0);
    step;
    reset = 1;

    for (int i = 0; i < N + 3; i++) begin
      if (i < N) op(tv[i].f, tv[i].w, tv[i].a, tv[i].b);
      else in_valid = 0;
      #1;
      if (i >= 2) begin
        if (i - 2 < N) begin
          chk($sformatf("vec%0d ov32", i - 2), ov2, 1);
          chk($sformatf("vec%0d res32", i - 2), res2, tv[i-2].e32);
          chk($sformatf("vec%0d ov64", i - 2), ov6, 1);
          chk($sformatf("vec%0d res64", i - 2), res6, tv[i-2].e64);
        end else begin
          chk("drain ov32", ov2, 0);
          chk("drain ov64", ov6, 0);
        end
      end
      if (i >= 3) begin
        chk($sformatf("vec%0d ov lat3", i - 3), ov3, 1);
        chk($sformatf("vec%0d res lat3", i - 3), res3, tv[i-3].e32);
      end
      step;
    end

    do_reset;
    out_ready = 0;
    op(3'd0, 0, 3, 5);   #1; chk("stall c0 rdy", rdy3, 1); step;
    op(3'd0, 0, 7, 11);  #1; chk("stall c1 rdy", rdy3, 1); step;
    op(3'd0, 0, 13, 17); #1; chk("stall c2 rdy", rdy3, 1); step;
    op(3'd0, 0, 2, 2);   #1;
    chk("stall c3 ov", ov3, 1);
    chk("stall c3 res", res3, 15);
    chk("stall c3 rdy", rdy3, 0);
    step;
    out_ready = 1;
    #1;
    chk("stall c4 ov", ov3, 1);
    chk("stall c4 res", res3, 15);
    chk("stall c4 rdy", rdy3, 1);
    step;
    in_valid = 0;
    #1; chk("stall c5 ov", ov3, 1); chk("stall c5 res", res3, 77); step;
    #1; chk("stall c6 ov", ov3, 1); chk("stall c6 res", res3, 221); step;
    #1; chk("stall c7 ov", ov3, 1); chk("stall c7 res", res3, 4); step;
    #1; chk("stall c8 ov", ov3, 0); chk("stall c8 busy", busy3, 0); step;

    do_reset;
    op(3'd0, 0, 3, 5);   #1; chk("flush c0 ov", ov3, 0); step;
    op(3'd0, 0, 7, 11);  #1; chk("flush c1 ov", ov3, 0); step;
    op(3'd0, 0, 13, 17); flush = 1; #1; chk("flush c2 ov", ov3, 0); step;
    flush = 0;
    op(3'd0, 0, 6, 7);   #1; chk("flush c3 ov", ov3, 0); chk("flush c3 busy", busy3, 0); step;
    in_valid = 0;
    #1; chk("flush c4 ov", ov3, 0); step;
    #1; chk("flush c5 ov", ov3, 0); step;
    #1; chk("flush c6 ov", ov3, 1); chk("flush c6 res", res3, 42); step;
    #1; chk("flush c7 ov", ov3, 0); step;

    op(3'd0, 0, 3, 5);  step;
    op(3'd0, 0, 7, 11); step;
    in_valid = 0;
    reset = 0;
    #1;
    chk("mrst ov2", ov2, 0);
    chk("mrst busy2", busy2, 0);
    chk("mrst ov3", ov3, 0);
    chk("mrst busy3", busy3, 0);
    chk("mrst res3", res3, 0);
    step;
    reset = 1;
    op(3'd0, 0, 9, 9);
    #1; chk("mrst c3 ov2", ov2, 0); chk("mrst c3 ov3", ov3, 0); step;
    in_valid = 0;
    #1; chk("mrst c4 ov2", ov2, 0); chk("mrst c4 ov3", ov3, 0); step;
    #1; chk("mrst c5 ov2", ov2, 1); chk("mrst c5 res2", res2, 81); chk("mrst c5 ov3", ov3, 0); step;
    #1; chk("mrst c6 ov2", ov2, 0); chk("mrst c6 ov3", ov3, 1); chk("mrst c6 res3", res3, 81); step;
    #1; chk("mrst c7 ov3", ov3, 0); chk("mrst c7 busy3", busy3, 0); chk("mrst c7 busy2", busy2, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
